fetch_npc: RTL and testbench
============================

// Module: fetch_npc
// PURPOSE
//  Instruction-fetch and next-PC stage directly upstream of the control decoder. Owns the PC register,
//  fetches one instruction word per request from instruction memory over a req/ready handshake, and
//  presents it to decode. Holds it until the core commits, then resolves the next PC from the decoder's
//  BranchType/JumpType plus the ALU flags. Non-pipelined: one instruction in flight.
// PARAMETERS
//  PC_W      10        PC width in words; IM depth = 2**PC_W words; legal range 2..30
//  RESET_PC  0         word address loaded on reset
// PORTS
//  clk          in   1     sole clock; all state changes on the rising edge
//  rst          in   1     synchronous, active-high reset
//  im_req       out  1     fetch request; high exactly one cycle per fetch
//  im_addr      out  PC_W  word address; valid while im_req=1
//  im_ready     in   1     one-cycle pulse; im_rdata valid in the same cycle
//  im_rdata     in   32    instruction word
//  instr        out  32    latched instruction to decode
//  instr_valid  out  1     instr/pc/pc1 valid; awaiting commit
//  pc           out  PC_W  word address of instr
//  pc1          out  PC_W  pc+1 (mod 2**PC_W); link value for jal/jalr
//  commit       in   1     core finished instr; sampled only while instr_valid=1
//  branch_type  in   3     decoder BranchType
//  jump_type    in   2     decoder JumpType
//  alu_zero     in   1     ALU result == 0
//  alu_neg      in   1     ALU result bit 31
//  rs_val       in   32    rs register value, byte address for jr/jalr
//  misalign_err out  1     sticky flag: register jump with rs_val[1:0]!=0
//  retire_cnt   out  32    committed-instruction count; wraps 2**32-1 -> 0
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=S_REQ, im_req=0, instr=0, instr_valid=0, misalign_err=0, retire_cnt=0.
//  FSM:
//  - S_REQ:  im_req=1, im_addr=pc for exactly one cycle -> S_WAIT.
//  - S_WAIT: im_req=0; im_ready=1 -> instr<=im_rdata, instr_valid<=1, go to S_EXEC; otherwise stay.
//  - S_EXEC: commit=1 -> pc<=npc, instr_valid<=0, retire_cnt++, go to S_REQ; otherwise hold all outputs.
//  im_ready is ignored outside S_WAIT. commit is ignored outside S_EXEC.
//  Minimum rate: 3 cycles/instr (REQ, WAIT with im_ready, EXEC with commit). No upper bound on waiting.
//  Branch decode (taken): beq zero | bne !zero | bgez !neg | bltz neg | bgtz !neg&!zero | blez neg|zero.
//  npc by jump_type:
//  - No_Jump:        pc1.
//  - OffsetTypeJump: taken ? pc1+sext(instr[15:0]) truncated to PC_W : pc1;
//                    with branch_type=no_branch -> pc1.
//  - PseudoTypeJump: instr[PC_W-1:0] (upper pc1 bits concatenated when PC_W>26).
//  - RegTypeJump:    rs_val[PC_W+1:2]; rs_val[1:0]!=0 sets misalign_err (cleared only by rst),
//                    jump still taken.
//  All PC arithmetic wraps mod 2**PC_W; pc=2**PC_W-1 gives pc1=0.
//  rst in any state overrides everything next edge; IM shares rst and drops any outstanding request.
// STRUCTURE
//  Package mips_defs (shared with ctrl):
//  - BranchType encodings: no_branch=0, beq=1, bne=2, bgez=3, bltz=4, bgtz=5, blez=6.
//  - JumpType encodings: No_Jump=0, OffsetTypeJump=1, PseudoTypeJump=2, RegTypeJump=3.
//  - State encodings S_REQ/S_WAIT/S_EXEC.
//  One sub-module: npc_calc (combinational next-PC and branch-taken resolution); FSM and registers
//  live in fetch_npc.
// TESTING
//  T1 reset, RESET_PC=4: im_req=1,im_addr=4 at cycle 1; im_ready cycle 3 -> instr_valid=1 cycle 4.
//  T2 beq, pc=8, imm=0xFFFE, alu_zero=1, commit -> next im_addr=7; alu_zero=0 -> im_addr=9.
//  T3 bgtz: alu_neg=0, alu_zero=1 -> not taken, pc1; blez same flags -> taken.
//  T4 jr, rs_val=0x103 -> im_addr=0x40, misalign_err=1 and stays after a later aligned jr.
//  T5 commit/im_ready pulses in wrong states ignored; pc=1023,No_Jump -> im_addr=0; retire_cnt wraps.
//  T6 rst asserted in S_WAIT with im_ready same cycle -> instr_valid=0, pc=RESET_PC, fresh im_req.

Source files
------------

// File: rtl/fetch_npc_pkg.sv
// Shared MIPS decode encodings (BranchType/JumpType) and fetch FSM states.
// Also used by the control decoder, hence the package name.
package mips_defs;

  typedef enum logic [2:0] {
    no_branch = 3'd0,
    beq       = 3'd1,
    bne       = 3'd2,
    bgez      = 3'd3,
    bltz      = 3'd4,
    bgtz      = 3'd5,
    blez      = 3'd6
  } branch_t;

  typedef enum logic [1:0] {
    No_Jump        = 2'd0,
    OffsetTypeJump = 2'd1,
    PseudoTypeJump = 2'd2,
    RegTypeJump    = 2'd3
  } jump_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  // Condition evaluation from ALU flags; unknown encodings are never taken.
  function automatic logic branch_taken(input logic [2:0] bt, input logic zero,
                                        input logic neg);
    logic t;
    t = 1'b0;
    case (bt)
      beq:     t = zero;
      bne:     t = !zero;
      bgez:    t = !neg;
      bltz:    t = neg;
      bgtz:    t = !neg && !zero;
      blez:    t = neg || zero;
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/fetch_npc_if.sv
// Instruction-memory request/response bus: one-cycle req, one-cycle ready pulse with data.
interface fetch_npc_if #(
  parameter int PC_W = 10
);
  logic            im_req;
  logic [PC_W-1:0] im_addr;
  logic            im_ready;
  logic [31:0]     im_rdata;

  modport master (output im_req, im_addr, input im_ready, im_rdata);
  modport slave  (input im_req, im_addr, output im_ready, im_rdata);
endinterface

// File: rtl/fetch_npc_calc.sv
// Combinational next-PC resolution from decoder jump/branch type and ALU flags.
module npc_calc
  import mips_defs::*;
#(
  parameter int PC_W = 10
) (
  input  logic [PC_W-1:0] pc1,
  input  logic [31:0]     instr,
  input  logic [2:0]      branch_type,
  input  logic [1:0]      jump_type,
  input  logic            alu_zero,
  input  logic            alu_neg,
  input  logic [31:0]     rs_val,
  output logic [PC_W-1:0] npc,
  output logic            taken,
  output logic            misalign
);

  logic [31:0]     off;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] pseudo_tgt;
  logic            unused_ok;

  assign off    = {{16{instr[15]}}, instr[15:0]};
  assign br_tgt = pc1 + off[PC_W-1:0];

  // The 26-bit pseudo-direct field only covers the whole PC for narrow PCs.
  generate
    if (PC_W > 26) begin : g_wide
      assign pseudo_tgt = {pc1[PC_W-1:26], instr[25:0]};
    end else begin : g_narrow
      assign pseudo_tgt = instr[PC_W-1:0];
    end
  endgenerate

  assign taken     = branch_taken(branch_type, alu_zero, alu_neg);
  assign misalign  = (jump_type == RegTypeJump) && (rs_val[1:0] != 2'b00);
  assign unused_ok = ^{rs_val, instr};

  always_comb begin
    npc = pc1;
    case (jump_type)
      OffsetTypeJump: npc = taken ? br_tgt : pc1;
      PseudoTypeJump: npc = pseudo_tgt;
      RegTypeJump:    npc = rs_val[PC_W+1:2];
      default:        npc = pc1;
    endcase
  end

endmodule

// File: rtl/fetch_npc.sv
// Fetch / next-PC stage: owns the PC, fetches one word, holds it for decode until commit.
// Non-pipelined: REQ -> WAIT -> EXEC, one instruction in flight.
module fetch_npc
  import mips_defs::*;
#(
  parameter int PC_W     = 10,
  parameter int RESET_PC = 0
) (
  input  logic             clk,
  input  logic             rst,
  fetch_npc_if.master      im,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc1,
  input  logic             commit,
  input  logic [2:0]       branch_type,
  input  logic [1:0]       jump_type,
  input  logic             alu_zero,
  input  logic             alu_neg,
  input  logic [31:0]      rs_val,
  output logic             misalign_err,
  output logic [31:0]      retire_cnt
);

  localparam logic [PC_W-1:0] RST_PC = RESET_PC[PC_W-1:0];

  state_t          state;
  logic [PC_W-1:0] npc;
  logic            taken;
  logic            misalign;

  assign pc1        = pc + PC_W'(1);
  assign im.im_addr = pc;

  npc_calc #(.PC_W(PC_W)) u_npc (
    .pc1         (pc1),
    .instr       (instr),
    .branch_type (branch_type),
    .jump_type   (jump_type),
    .alu_zero    (alu_zero),
    .alu_neg     (alu_neg),
    .rs_val      (rs_val),
    .npc         (npc),
    .taken       (taken),
    .misalign    (misalign)
  );

  // im_req is registered, so it is high during the first S_WAIT cycle;
  // a same-cycle im_ready response is accepted there.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_REQ;
      pc           <= RST_PC;
      im.im_req    <= 1'b0;
      instr        <= '0;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
      retire_cnt   <= '0;
    end else begin
      case (state)
        S_REQ: begin
          im.im_req <= 1'b1;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          im.im_req <= 1'b0;
          if (im.im_ready) begin
            instr       <= im.im_rdata;
            instr_valid <= 1'b1;
            state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (commit) begin
            pc           <= npc;
            instr_valid  <= 1'b0;
            retire_cnt   <= retire_cnt + 32'd1;
            misalign_err <= misalign_err | misalign;
            state        <= S_REQ;
          end
        end
        default: begin
          im.im_req <= 1'b0;
          state     <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_npc.sv
// Randomized bench for fetch_npc against an arithmetic next-PC model.
module tb_fetch_npc;
  localparam int PC_W     = 10;
  localparam int RESET_PC = 4;
  localparam int M        = 1 << PC_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      instr;
  logic             instr_valid;
  logic [PC_W-1:0]  pc, pc1;
  logic             commit;
  logic [2:0]       branch_type;
  logic [1:0]       jump_type;
  logic             alu_zero, alu_neg;
  logic [31:0]      rs_val;
  logic             misalign_err;
  logic [31:0]      retire_cnt;

  fetch_npc_if #(.PC_W(PC_W)) bus ();

  fetch_npc #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .im(bus),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .pc1(pc1),
    .commit(commit), .branch_type(branch_type), .jump_type(jump_type),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .rs_val(rs_val),
    .misalign_err(misalign_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int mpc;
  bit mmis;
  int mcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int model_npc(input int cur, input logic [31:0] w, input int bt,
                                   input int jt, input bit z, input bit n,
                                   input logic [31:0] rs);
    int p1;
    bit tk;
    p1 = (cur + 1) % M;
    case (bt)
      1: tk = z;
      2: tk = !z;
      3: tk = !n;
      4: tk = n;
      5: tk = !n && !z;
      6: tk = n || z;
      default: tk = 0;
    endcase
    case (jt)
      1: return tk ? (((p1 + int'($signed(w[15:0]))) % M) + M) % M : p1;
      2: return int'(w & (M - 1));
      3: return int'((rs >> 2) & (M - 1));
      default: return p1;
    endcase
  endfunction

  task automatic do_reset;
    rst = 1'b1; commit = 1'b0; bus.im_ready = 1'b0; bus.im_rdata = '0;
    branch_type = '0; jump_type = '0; alu_zero = 0; alu_neg = 0; rs_val = '0;
    tick; tick;
    rst = 1'b0;
    mpc = RESET_PC; mmis = 0; mcnt = 0;
  endtask

  // One full fetch/execute/commit; stray commit and im_ready pulses are
  // injected where the DUT must ignore them.
  task automatic do_instr(input logic [31:0] w, input int bt, input int jt,
                          input bit z, input bit n, input logic [31:0] rs);
    int waits, lat, hold;
    waits = 0;
    while (!bus.im_req && waits < 20) begin
      commit = 1'($urandom_range(0, 1));
      tick;
      waits++;
    end
    commit = 1'b0;
    chk("req_latency", waits, 1);
    chk("im_addr", bus.im_addr, mpc);
    lat = $urandom_range(0, 3);
    for (int i = 0; i < lat; i++) begin
      commit = 1'($urandom_range(0, 1));
      tick;
      chk("req_one_cycle", bus.im_req, 0);
    end
    commit = 1'b0;
    bus.im_ready = 1'b1; bus.im_rdata = w;
    tick;
    bus.im_ready = 1'b0;
    chk("instr_valid", instr_valid, 1);
    chk("instr", instr, w);
    chk("pc", pc, mpc);
    chk("pc1", pc1, (mpc + 1) % M);
    chk("retire_cnt", retire_cnt, mcnt);
    hold = $urandom_range(0, 2);
    for (int i = 0; i < hold; i++) begin
      bus.im_ready = 1'b1; bus.im_rdata = $urandom;
      tick;
      bus.im_ready = 1'b0;
      chk("instr_hold", instr, w);
    end
    branch_type = 3'(bt); jump_type = 2'(jt); alu_zero = z; alu_neg = n; rs_val = rs;
    commit = 1'b1;
    tick;
    commit = 1'b0;
    if (jt == 3 && rs[1:0] != 2'b00) mmis = 1;
    mpc = model_npc(mpc, w, bt, jt, z, n, rs);
    mcnt++;
    chk("valid_drop", instr_valid, 0);
    chk("npc", pc, mpc);
    chk("misalign_err", misalign_err, mmis);
  endtask

  initial begin
    int waits;
    logic [31:0] w, rs;
    do_reset;
    // reset values observed before the first S_REQ edge
    chk("rst_req", bus.im_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_mis", misalign_err, 0);
    chk("rst_cnt", retire_cnt, 0);

    do_instr(32'h1234_5678, 0, 0, 0, 0, 0);            // to pc 5
    // beq taken / not taken from pc 8
    do_instr(32'h0, 0, 3, 0, 0, 32'd32);
    do_instr(32'h1000_FFFE, 1, 1, 1, 0, 0);
    chk("t2_taken", pc, 7);
    do_instr(32'h0, 0, 3, 0, 0, 32'd32);
    do_instr(32'h1000_FFFE, 1, 1, 0, 0, 0);
    chk("t2_not_taken", pc, 9);
    // bgtz vs blez with neg=0, zero=1
    do_instr(32'h1C00_0005, 5, 1, 1, 0, 0);
    chk("t3_bgtz", pc, 10);
    do_instr(32'h1800_0005, 6, 1, 1, 0, 0);
    chk("t3_blez", pc, 16);
    // misaligned register jump is still taken and sticky
    do_instr(32'h0, 0, 3, 0, 0, 32'h103);
    chk("t4_jr", pc, 10'h40);
    chk("t4_mis", misalign_err, 1);
    do_instr(32'h0, 0, 3, 0, 0, 32'h100);
    chk("t4_sticky", misalign_err, 1);
    // wrap at top of PC space
    do_instr(32'h0, 0, 3, 0, 0, 32'hFFC);
    chk("t5_top", pc, 1023);
    do_instr(32'h0, 0, 0, 0, 0, 0);
    chk("t5_wrap", pc, 0);

    for (int k = 0; k < 60; k++) begin
      w  = $urandom;
      rs = $urandom;
      if ($urandom_range(0, 3) != 0) rs[1:0] = 2'b00;
      do_instr(w, $urandom_range(0, 7), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs);
    end

    // reset in S_WAIT, coinciding with im_ready
    waits = 0;
    while (!bus.im_req && waits < 20) begin
      tick;
      waits++;
    end
    chk("t6_req_seen", bus.im_req, 1);
    bus.im_ready = 1'b1; bus.im_rdata = 32'hDEAD_BEEF; rst = 1'b1;
    tick;
    bus.im_ready = 1'b0; rst = 1'b0;
    mpc = RESET_PC; mmis = 0; mcnt = 0;
    chk("t6_valid", instr_valid, 0);
    chk("t6_pc", pc, RESET_PC);
    chk("t6_cnt", retire_cnt, 0);
    chk("t6_mis", misalign_err, 0);
    chk("t6_req_low", bus.im_req, 0);
    tick;
    chk("t6_fresh_req", bus.im_req, 1);
    chk("t6_addr", bus.im_addr, RESET_PC);
    bus.im_ready = 1'b1; bus.im_rdata = 32'h0000_0000;
    tick;
    bus.im_ready = 1'b0;
    chk("t6_refetch", instr_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
